// File: rtl/ppm_encoder.sv
// PPM encoder: fetches bytes from a source FIFO, slices each byte MSB-first into
// SYM_BITS-wide symbols and writes one timed pulse word per symbol to a pulse FIFO.
module ppm_encoder #(
    parameter int SYM_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] coarse_offset,
    input  logic        data_fifo_empty,
    input  logic [7:0]  data_fifo_data,
    output logic        data_fifo_read,
    input  logic        pulse_fifo_full,
    output logic        pulse_fifo_wr_en,
    output logic [31:0] pulse_fifo_wr_data,
    output logic [31:0] symbols_sent,
    output logic        busy,
    output logic [7:0]  state_out
);

    localparam int         NUM_SYMS = 8 / SYM_BITS;
    localparam logic [3:0] LAST_IDX = 4'(NUM_SYMS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_REQ = 2'd1,
        LATCH  = 2'd2,
        EMIT   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        read_q, read_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] count_q, count_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  idx_q, idx_d;

    logic [7:0]  sym;
    logic [15:0] coarse;
    logic [31:0] word;

    // The upper nibble of a symbol spills into the coarse delay; the lower nibble is the fine delay.
    always_comb begin
        sym    = shift_q >> (8 - SYM_BITS);
        coarse = coarse_offset + {12'b0, sym[7:4]};
        word   = {8'h01, coarse, 4'b0, sym[3:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            count_q   <= '0;
            shift_q   <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        read_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        shift_d   = shift_q;
        idx_d     = idx_q;

        case (state_q)
            IDLE: begin
                if (enable && !data_fifo_empty) begin
                    read_d  = 1'b1;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                state_d = LATCH;
            end
            LATCH: begin
                shift_d = data_fifo_data;
                idx_d   = '0;
                state_d = EMIT;
            end
            EMIT: begin
                // A full pulse FIFO freezes the byte in place so no symbol is lost or repeated.
                if (!pulse_fifo_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word;
                    shift_d   = shift_q << SYM_BITS;
                    idx_d     = idx_q + 4'd1;
                    count_d   = count_q + 32'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                wr_data_d = '0;
                count_d   = '0;
                shift_d   = '0;
                idx_d     = '0;
            end
        endcase
    end

    assign data_fifo_read     = read_q;
    assign pulse_fifo_wr_en   = wr_en_q;
    assign pulse_fifo_wr_data = wr_data_q;
    assign symbols_sent       = count_q;
    assign busy               = (state_q != IDLE);
    assign state_out          = {6'b0, state_q};

endmodule

// File: tb/tb_ppm_encoder.sv
// Testbench for ppm_encoder: three instances (SYM_BITS 4, 8, 2) share one clock and reset,
// each fed by a small source FIFO model; written pulse words are compared with an arithmetic model.
module tb_ppm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable   [3];
    logic [15:0] offset   [3];
    logic        empty    [3];
    logic [7:0]  fifoData [3];
    logic        rdStrobe [3];
    logic        full     [3];
    logic        wrEn     [3];
    logic [31:0] wrData   [3];
    logic [31:0] symSent  [3];
    logic        busyO    [3];
    logic [7:0]  stateO   [3];

    logic [7:0]  srcMem   [3][64];
    int          wrCnt    [3];
    int          rdPtr    [3];

    logic [33:0] obsQ[$];
    logic [33:0] expQ[$];
    int          obsIdx;
    logic [31:0] expCount [3];
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    ppm_encoder #(.SYM_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable[0]), .coarse_offset(offset[0]),
        .data_fifo_empty(empty[0]), .data_fifo_data(fifoData[0]), .data_fifo_read(rdStrobe[0]),
        .pulse_fifo_full(full[0]), .pulse_fifo_wr_en(wrEn[0]), .pulse_fifo_wr_data(wrData[0]),
        .symbols_sent(symSent[0]), .busy(busyO[0]), .state_out(stateO[0]));

    ppm_encoder #(.SYM_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .enable(enable[1]), .coarse_offset(offset[1]),
        .data_fifo_empty(empty[1]), .data_fifo_data(fifoData[1]), .data_fifo_read(rdStrobe[1]),
        .pulse_fifo_full(full[1]), .pulse_fifo_wr_en(wrEn[1]), .pulse_fifo_wr_data(wrData[1]),
        .symbols_sent(symSent[1]), .busy(busyO[1]), .state_out(stateO[1]));

    ppm_encoder #(.SYM_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable[2]), .coarse_offset(offset[2]),
        .data_fifo_empty(empty[2]), .data_fifo_data(fifoData[2]), .data_fifo_read(rdStrobe[2]),
        .pulse_fifo_full(full[2]), .pulse_fifo_wr_en(wrEn[2]), .pulse_fifo_wr_data(wrData[2]),
        .symbols_sent(symSent[2]), .busy(busyO[2]), .state_out(stateO[2]));

    assign empty[0] = (rdPtr[0] == wrCnt[0]);
    assign empty[1] = (rdPtr[1] == wrCnt[1]);
    assign empty[2] = (rdPtr[2] == wrCnt[2]);

    // Source FIFO with registered read data: a strobe pops the head onto the data bus next cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rdStrobe[i] === 1'b1 && rdPtr[i] != wrCnt[i]) begin
                fifoData[i] <= srcMem[i][rdPtr[i] % 64];
                rdPtr[i]    <= rdPtr[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wrEn[i] === 1'b1) obsQ.push_back({2'(i), wrData[i]});
        end
    end

    function automatic int symBitsOf(input int inst);
        case (inst)
            0:       return 4;
            1:       return 8;
            default: return 2;
        endcase
    endfunction

    // Symbol k of a byte is the k-th SYM_BITS-wide digit counted from the most significant end.
    function automatic logic [31:0] modelWord(input int sb, input logic [7:0] b,
                                              input logic [15:0] off, input int k);
        int sym;
        int coarseVal;
        sym       = (int'(b) >> (8 - (k + 1) * sb)) % (1 << sb);
        coarseVal = (int'(off) + sym / 16) % 65536;
        return {8'h01, 16'(coarseVal), 8'(sym % 16)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic loadByte(input int inst, input logic [7:0] b);
        srcMem[inst][wrCnt[inst] % 64] = b;
        wrCnt[inst]++;
    endtask

    task automatic expectByte(input int inst, input logic [7:0] b);
        int sb;
        sb = symBitsOf(inst);
        for (int k = 0; k < 8 / sb; k++) begin
            expQ.push_back({2'(inst), modelWord(sb, b, offset[inst], k)});
        end
        expCount[inst] = expCount[inst] + 32'(8 / sb);
    endtask

    task automatic checkQueue(input int inst, input string tag);
        int n;
        n = obsQ.size() - obsIdx;
        checkOutput({tag, "_count"}, 64'(n), 64'(expQ.size()));
        for (int j = 0; j < n && j < expQ.size(); j++) begin
            checkOutput($sformatf("%s_word%0d", tag, j), 64'(obsQ[obsIdx + j]), 64'(expQ[j]));
        end
        obsIdx = obsQ.size();
        expQ.delete();
        checkOutput({tag, "_symsent"}, 64'(symSent[inst]), 64'(expCount[inst]));
        checkOutput({tag, "_busy"}, 64'(busyO[inst]), 64'(0));
        checkOutput({tag, "_state"}, 64'(stateO[inst]), 64'(0));
        checkOutput({tag, "_read"}, 64'(rdStrobe[inst]), 64'(0));
    endtask

    task automatic waitFirstWrite(input int inst, input string tag);
        int  cyc;
        bit  seen;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (wrEn[inst] === 1'b1) seen = 1;
        end
        checkOutput({tag, "_firstwr"}, 64'(seen), 64'(1));
    endtask

    task automatic applyStimulus(input int inst, input bit stall, input bit checkLat, input string tag);
        int cyc;
        int strobeAt;
        int wrAt;
        bit done;
        cyc      = 0;
        strobeAt = -1;
        wrAt     = -1;
        enable[inst] = 1'b1;
        while ((obsQ.size() - obsIdx) < expQ.size() && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (rdStrobe[inst] === 1'b1 && strobeAt < 0) strobeAt = cyc;
            if (wrEn[inst] === 1'b1 && wrAt < 0) wrAt = cyc;
            full[inst] = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        done = ((obsQ.size() - obsIdx) >= expQ.size());
        full[inst]   = 1'b0;
        enable[inst] = 1'b0;
        checkOutput({tag, "_done"}, 64'(done), 64'(1));
        if (checkLat) checkOutput({tag, "_latency"}, 64'(wrAt - strobeAt), 64'(3));
        repeat (4) @(negedge clk);
        checkQueue(inst, tag);
    endtask

    initial begin
        bit         sawEvent;
        bit         stall;
        int         nb;
        logic [7:0] v;

        checks = 0;
        errors = 0;
        obsIdx = 0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enable[i]   = 1'b0;
            offset[i]   = 16'h0;
            full[i]     = 1'b0;
            wrCnt[i]    = 0;
            expCount[i] = 32'h0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset%0d_wren", i),    64'(wrEn[i]),     64'(0));
            checkOutput($sformatf("reset%0d_wrdata", i),  64'(wrData[i]),   64'(0));
            checkOutput($sformatf("reset%0d_symsent", i), 64'(symSent[i]),  64'(0));
            checkOutput($sformatf("reset%0d_busy", i),    64'(busyO[i]),    64'(0));
            checkOutput($sformatf("reset%0d_state", i),   64'(stateO[i]),   64'(0));
            checkOutput($sformatf("reset%0d_read", i),    64'(rdStrobe[i]), 64'(0));
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        offset[0] = 16'h0003;
        loadByte(0, 8'hA5);
        expectByte(0, 8'hA5);
        applyStimulus(0, 0, 1, "r031");

        offset[1] = 16'h0010;
        loadByte(1, 8'h3C);
        expectByte(1, 8'h3C);
        applyStimulus(1, 0, 1, "r032");

        offset[1] = 16'hFFFF;
        loadByte(1, 8'h20);
        expectByte(1, 8'h20);
        applyStimulus(1, 0, 1, "r033");

        // Pulse FIFO reports full for five cycles right after the first symbol lands.
        offset[2] = 16'h0040;
        loadByte(2, 8'hE4);
        expectByte(2, 8'hE4);
        enable[2] = 1'b1;
        waitFirstWrite(2, "r034");
        full[2]  = 1'b1;
        sawEvent = 0;
        repeat (5) begin
            @(negedge clk);
            if (wrEn[2] === 1'b1) sawEvent = 1;
        end
        full[2] = 1'b0;
        checkOutput("r034_stall_nowrite", 64'(sawEvent), 64'(0));
        applyStimulus(2, 0, 0, "r034");

        // Enable drops during the first byte; the second byte must stay in the source FIFO.
        offset[0] = 16'h0003;
        loadByte(0, 8'h5A);
        loadByte(0, 8'hC3);
        expectByte(0, 8'h5A);
        enable[0] = 1'b1;
        waitFirstWrite(0, "r035");
        enable[0] = 1'b0;
        sawEvent  = 0;
        repeat (12) begin
            @(negedge clk);
            if (rdStrobe[0] === 1'b1) sawEvent = 1;
        end
        checkOutput("r035_noread", 64'(sawEvent), 64'(0));
        checkOutput("r035_unread", 64'(wrCnt[0] - rdPtr[0]), 64'(1));
        checkQueue(0, "r035");
        expectByte(0, 8'hC3);
        applyStimulus(0, 0, 1, "r035_resume");

        // Reset lands after the first symbol of 0xA5; the rest of that byte must never appear.
        offset[0] = 16'h0003;
        loadByte(0, 8'hA5);
        expectByte(0, 8'hA5);
        void'(expQ.pop_back());
        enable[0] = 1'b1;
        waitFirstWrite(0, "r036");
        enable[0] = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("r036_rst_wren",    64'(wrEn[0]),    64'(0));
        checkOutput("r036_rst_wrdata",  64'(wrData[0]),  64'(0));
        checkOutput("r036_rst_symsent", 64'(symSent[0]), 64'(0));
        checkOutput("r036_rst_busy",    64'(busyO[0]),   64'(0));
        checkOutput("r036_rst_state",   64'(stateO[0]),  64'(0));
        for (int i = 0; i < 3; i++) expCount[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkQueue(0, "r036");
        loadByte(0, 8'h0F);
        expectByte(0, 8'h0F);
        applyStimulus(0, 0, 1, "r036_after");

        for (int inst = 0; inst < 3; inst++) begin
            for (int it = 0; it < 6; it++) begin
                offset[inst] = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                           : 16'($urandom);
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    v = 8'($urandom);
                    loadByte(inst, v);
                    expectByte(inst, v);
                end
                stall = 1'($urandom_range(0, 1));
                applyStimulus(inst, stall, !stall, $sformatf("rand%0d_%0d", inst, it));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
